// File: rtl/sync_fifo_status.sv
// Synchronous FIFO with occupancy counter, almost flags and sticky errors.
// Single clock; the storage array itself is never reset.
module sync_fifo_status #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic pop_ok;
  logic push_ok;
  logic do_pop;
  logic do_push;
  logic push_rej;
  logic pop_rej;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok   = pop_i & (count != '0);
  assign push_ok  = push_i
                  & ((count != CW'(DEPTH)) | pop_ok);
  assign do_pop   = pop_ok & ~flush_i;
  assign do_push  = push_ok & ~flush_i;
  assign push_rej = push_i & ~push_ok;
  assign pop_rej  = pop_i & ~pop_ok;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pop_valid_o <= 1'b0;
    end else begin
      pop_valid_o <= do_pop;
      if (do_pop) begin
        pop_data_o <= mem[rd_ptr];
        rd_ptr     <= inc(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= inc(wr_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An error in the clearing cycle wins over clr_err_i.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_err_i) begin
      overflow_o  <= push_rej;
      underflow_o <= pop_rej;
    end else begin
      overflow_o  <= overflow_o | push_rej;
      underflow_o <= underflow_o | pop_rej;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  assign count_o        = count;
  assign empty_o        = (count == '0);
  assign full_o         = (count == CW'(DEPTH));
  assign almost_full_o  = (int'(count) >= AF_LEVEL);
  assign almost_empty_o = (int'(count) <= AE_LEVEL);

endmodule

// File: tb/tb_sync_fifo_status.sv
// Self-checking bench for sync_fifo_status.
// Reference model: a queue of words plus sticky error bits.
module tb_sync_fifo_status;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          push_i = 1'b0;
  logic [W-1:0]  push_data_i = '0;
  logic          pop_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [W-1:0]  pop_data_o;
  logic          pop_valid_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          underflow_o;

  sync_fifo_status #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .flush_i(flush_i),
    .clr_err_i(clr_err_i),
    .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o),
    .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [W-1:0] q[$];
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_ov = 1'b0;
  logic         m_un = 1'b0;
  int n_chk  = 0;
  int n_pass = 0;

  // Drive one cycle of inputs, advance the model, settle past the edge.
  task automatic cycle(input logic pu, input logic [W-1:0] d,
                       input logic po, input logic fl = 1'b0,
                       input logic cl = 1'b0);
    logic pa, pua;
    push_i = pu; push_data_i = d; pop_i = po;
    flush_i = fl; clr_err_i = cl;
    @(posedge clk_i);
    pa  = po && q.size() != 0;
    pua = pu && (q.size() != D || pa);
    m_ov = (cl ? 1'b0 : m_ov) | (pu && !pua);
    m_un = (cl ? 1'b0 : m_un) | (po && !pa);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      m_valid = pa;
      if (pa) m_data = q.pop_front();
      if (pua) q.push_back(d);
    end
    #1;
    push_i = 1'b0; pop_i = 1'b0;
    flush_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({count_o, empty_o, almost_empty_o, full_o, almost_full_o,
         pop_valid_o, pop_data_o, overflow_o, underflow_o}
        !== {CW'(0), 4'b1100, 1'b0, W'(0), 2'b00})
      $display("FAIL reset: cnt=%0d e=%b ae=%b f=%b af=%b v=%b d=%h ov=%b un=%b",
               count_o, empty_o, almost_empty_o, full_o, almost_full_o,
               pop_valid_o, pop_data_o, overflow_o, underflow_o);
    else n_pass++;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, v[i], 1'b0);
      n_chk++;
      if ({count_o, full_o, almost_full_o} !==
          {CW'(i + 1), i == 3, i >= 2})
        $display("FAIL fill%0d: cnt=%0d f=%b af=%b want cnt=%0d",
                 i, count_o, full_o, almost_full_o, i + 1);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_chk++;
      if ({pop_valid_o, pop_data_o, count_o} !==
          {1'b1, v[i], CW'(3 - i)})
        $display("FAIL drain%0d: v=%b d=%h cnt=%0d want d=%h cnt=%0d",
                 i, pop_valid_o, pop_data_o, count_o, v[i], 3 - i);
      else n_pass++;
    end
    cycle(1'b0, '0, 1'b0);
    n_chk++;
    if ({pop_valid_o, pop_data_o, empty_o} !== {1'b0, 8'h44, 1'b1})
      $display("FAIL hold: v=%b d=%h e=%b want 0/44/1",
               pop_valid_o, pop_data_o, empty_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'hA0 + i), 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    n_chk++;
    if ({overflow_o, count_o} !== {1'b1, CW'(4)})
      $display("FAIL overflow: ov=%b cnt=%0d want 1/4",
               overflow_o, count_o);
    else n_pass++;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (overflow_o !== 1'b0)
      $display("FAIL clr_err: ov=%b want 0", overflow_o);
    else n_pass++;
    // Push 0x66 and pop while full.
    cycle(1'b1, 8'h66, 1'b1);
    n_chk++;
    if ({pop_valid_o, pop_data_o, count_o, overflow_o} !==
        {1'b1, 8'hA0, CW'(4), 1'b0})
      $display("FAIL full_pp: v=%b d=%h cnt=%0d ov=%b want 1/a0/4/0",
               pop_valid_o, pop_data_o, count_o, overflow_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    n_chk++;
    if ({pop_data_o, empty_o} !== {8'h66, 1'b1})
      $display("FAIL full_pp_last: d=%h e=%b want 66/1",
               pop_data_o, empty_o);
    else n_pass++;
  endtask

  task automatic test_empty_pushpop();
    cycle(1'b1, 8'h77, 1'b1);
    n_chk++;
    if ({count_o, pop_valid_o, underflow_o} !== {CW'(1), 2'b01})
      $display("FAIL empty_pp: cnt=%0d v=%b un=%b want 1/0/1",
               count_o, pop_valid_o, underflow_o);
    else n_pass++;
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({pop_valid_o, pop_data_o, underflow_o} !== {1'b1, 8'h77, 1'b0})
      $display("FAIL empty_pp_pop: v=%b d=%h un=%b want 1/77/0",
               pop_valid_o, pop_data_o, underflow_o);
    else n_pass++;
  endtask

  task automatic test_flush_wrap();
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    n_chk++;
    if ({count_o, empty_o, pop_valid_o} !== {CW'(0), 2'b10})
      $display("FAIL flush: cnt=%0d e=%b v=%b want 0/1/0",
               count_o, empty_o, pop_valid_o);
    else n_pass++;
    cycle(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, W'(8'h10 + i), 1'b1);
      n_chk++;
      if ({pop_valid_o, pop_data_o, count_o} !==
          {1'b1, m_data, CW'(1)})
        $display("FAIL wrap%0d: v=%b d=%h cnt=%0d want d=%h cnt=1",
                 i, pop_valid_o, pop_data_o, count_o, m_data);
      else n_pass++;
    end
    cycle(1'b0, '0, 1'b1);
    n_chk++;
    if (pop_data_o !== 8'h19)
      $display("FAIL wrap_last: d=%h want 19", pop_data_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h4D, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h5E, 1'b0);
    #2 reset_ni = 1'b0;
    #1;
    n_chk++;
    if ({count_o, empty_o, almost_empty_o, full_o, almost_full_o,
         pop_valid_o, pop_data_o, overflow_o, underflow_o}
        !== {CW'(0), 4'b1100, 1'b0, W'(0), 2'b00})
      $display("FAIL async_reset: cnt=%0d e=%b v=%b d=%h ov=%b un=%b",
               count_o, empty_o, pop_valid_o, pop_data_o,
               overflow_o, underflow_o);
    else n_pass++;
    q.delete();
    m_data = '0; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    #2 reset_ni = 1'b1;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'hB6, 1'b0);
    cycle(1'b0, '0, 1'b1);
    n_chk++;
    if ({pop_valid_o, pop_data_o, count_o} !== {1'b1, 8'hA5, CW'(1)})
      $display("FAIL post_reset: v=%b d=%h cnt=%0d want 1/a5/1",
               pop_valid_o, pop_data_o, count_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 1500; i++) begin
      bias = ((i / 40) % 2 == 0) ? 75 : 30;
      cycle($urandom_range(99) < bias, W'($urandom),
            $urandom_range(99) < (100 - bias),
            $urandom_range(31) == 0, $urandom_range(15) == 0);
      n_chk++;
      if ({count_o, empty_o, full_o, almost_full_o, almost_empty_o,
           pop_valid_o, overflow_o, underflow_o} !==
          {CW'(q.size()), q.size() == 0, q.size() == D,
           q.size() >= 3, q.size() <= 1, m_valid, m_ov, m_un})
        $display("FAIL rand%0d: cnt=%0d v=%b ov=%b un=%b want cnt=%0d v=%b ov=%b un=%b",
                 i, count_o, pop_valid_o, overflow_o, underflow_o,
                 q.size(), m_valid, m_ov, m_un);
      else n_pass++;
      n_chk++;
      if (pop_data_o !== m_data)
        $display("FAIL rand_data%0d: d=%h want %h", i, pop_data_o, m_data);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty_pushpop();
    test_flush_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
